// File: rtl/gpr_file_mp_if.sv
// ============================================================================
// Module      : gpr_file_mp_if
// Description : Bus bundle for the multi-port GPR file (write, reserve, two
//               read ports, scoreboard and debug view).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpr_file_mp_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    localparam int SEL_W   = $clog2(NUM_REGS)
);
    logic                         wr_en;
    logic [SEL_W-1:0]             wr_sel;
    logic [DATA_W-1:0]            wr_data;
    logic                         rsv_en;
    logic [SEL_W-1:0]             rsv_sel;
    logic                         rd_a_en;
    logic [SEL_W-1:0]             rd_a_sel;
    logic [DATA_W-1:0]            rd_a_data;
    logic                         rd_a_valid;
    logic                         rd_b_en;
    logic [SEL_W-1:0]             rd_b_sel;
    logic [DATA_W-1:0]            rd_b_data;
    logic                         rd_b_valid;
    logic [NUM_REGS-1:0]          busy;
    logic                         rsv_err;
    logic [NUM_REGS*DATA_W-1:0]   reg_flat;

    modport master (
        output wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        output rd_a_en, rd_a_sel, rd_b_en, rd_b_sel,
        input  rd_a_data, rd_a_valid, rd_b_data, rd_b_valid,
        input  busy, rsv_err, reg_flat
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        input  rd_a_en, rd_a_sel, rd_b_en, rd_b_sel,
        output rd_a_data, rd_a_valid, rd_b_data, rd_b_valid,
        output busy, rsv_err, reg_flat
    );
endinterface

`default_nettype wire

// File: rtl/gpr_file_mp.sv
// ============================================================================
// Module      : gpr_file_mp
// Description : Parametrised GPR file, 1 write / 2 registered read ports with
//               busy scoreboard. Optional write-through forwarding: GPR_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_file_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int R0_ZERO  = 0,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  wire         clk,
    input  wire         reset,
    gpr_file_mp_if.slave bus
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            rsv_err_q, rsv_err_d;
    logic [DATA_W-1:0]               rd_a_data_q, rd_b_data_q;
    logic                            rd_a_valid_q, rd_b_valid_q;

    logic                            wr_hit, rsv_hit;
    logic [DATA_W:0]                 rd_a_res, rd_b_res;

    // A select is actionable only if it names a real, writable register.
    function automatic logic sel_ok(input logic [SEL_W-1:0] sel);
        return (int'(sel) < NUM_REGS) && !((R0_ZERO != 0) && (sel == '0));
    endfunction

    assign wr_hit  = bus.wr_en  && sel_ok(bus.wr_sel);
    assign rsv_hit = bus.rsv_en && sel_ok(bus.rsv_sel);

    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        rsv_err_d = rsv_err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit && (bus.wr_sel == SEL_W'(i))) begin
                regs_d[i] = bus.wr_data;
                busy_d[i] = 1'b0;
            end
            // Reserve is applied after the write so a new pending writer wins.
            if (rsv_hit && (bus.rsv_sel == SEL_W'(i))) begin
                busy_d[i] = 1'b1;
                if (busy_q[i] && !(bus.wr_en && (bus.wr_sel == bus.rsv_sel))) begin
                    rsv_err_d = 1'b1;
                end
            end
        end
    end

    // Returns {valid, data}; out-of-range selects fall through to all zeros.
    function automatic logic [DATA_W:0] read_port(input logic [SEL_W-1:0] sel);
        logic [DATA_W:0] res;
        res = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                res = {~busy_q[i], regs_q[i]};
            end
        end
`ifdef GPR_BYPASS_EN
        if (wr_hit && (bus.wr_sel == sel)) begin
            res = {~(rsv_hit && (bus.rsv_sel == sel)), bus.wr_data};
        end
`endif
        return res;
    endfunction

    assign rd_a_res = read_port(bus.rd_a_sel);
    assign rd_b_res = read_port(bus.rd_b_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q       <= '0;
            busy_q       <= '0;
            rsv_err_q    <= 1'b0;
            rd_a_data_q  <= '0;
            rd_a_valid_q <= 1'b0;
            rd_b_data_q  <= '0;
            rd_b_valid_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
            if (bus.rd_a_en) begin
                rd_a_data_q  <= rd_a_res[DATA_W-1:0];
                rd_a_valid_q <= rd_a_res[DATA_W];
            end else begin
                rd_a_valid_q <= 1'b0;
            end
            if (bus.rd_b_en) begin
                rd_b_data_q  <= rd_b_res[DATA_W-1:0];
                rd_b_valid_q <= rd_b_res[DATA_W];
            end else begin
                rd_b_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rd_a_data  = rd_a_data_q;
    assign bus.rd_a_valid = rd_a_valid_q;
    assign bus.rd_b_data  = rd_b_data_q;
    assign bus.rd_b_valid = rd_b_valid_q;
    assign bus.busy       = busy_q;
    assign bus.rsv_err    = rsv_err_q;
    assign bus.reg_flat   = regs_q;

endmodule

`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
// ============================================================================
// Module      : tb_gpr_file_mp
// Description : Directed self-checking bench for gpr_file_mp (6 regs, R0 zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpr_file_mp;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 6;

`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    gpr_file_mp_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

    gpr_file_mp #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0; bus.wr_sel   = '0; bus.wr_data = '0;
        bus.rsv_en  = 1'b0; bus.rsv_sel  = '0;
        bus.rd_a_en = 1'b0; bus.rd_a_sel = '0;
        bus.rd_b_en = 1'b0; bus.rd_b_sel = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int sel, input logic [15:0] d);
        bus.wr_en = 1'b1; bus.wr_sel = 3'(sel); bus.wr_data = d;
    endtask

    task automatic rsv(input int sel);
        bus.rsv_en = 1'b1; bus.rsv_sel = 3'(sel);
    endtask

    task automatic rda(input int sel);
        bus.rd_a_en = 1'b1; bus.rd_a_sel = 3'(sel);
    endtask

    task automatic rdb(input int sel);
        bus.rd_b_en = 1'b1; bus.rd_b_sel = 3'(sel);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_flat",    bus.reg_flat,   '0);
        check("rst_busy",    bus.busy,       '0);
        check("rst_a_valid", bus.rd_a_valid, 1'b0);
        check("rst_b_valid", bus.rd_b_valid, 1'b0);
        check("rst_rsv_err", bus.rsv_err,    1'b0);

        // Basic write then read
        wr(3, 16'hAAAA); tick();
        check("wr3_flat", bus.reg_flat[3*16 +: 16], 16'hAAAA);
        rda(3); tick();
        check("rd3_data",  bus.rd_a_data,  16'hAAAA);
        check("rd3_valid", bus.rd_a_valid, 1'b1);

        // Reserve, read-while-busy, write-back clears busy
        rsv(5); tick();
        check("rsv5_busy", bus.busy, 6'b100000);
        rdb(5); tick();
        check("rd5_busy_valid", bus.rd_b_valid, 1'b0);
        wr(5, 16'h1234); tick();
        check("wb5_busy", bus.busy, 6'b000000);
        rdb(5); tick();
        check("rd5_data",  bus.rd_b_data,  16'h1234);
        check("rd5_valid", bus.rd_b_valid, 1'b1);
        tick();
        check("rdb_hold_data",  bus.rd_b_data,  16'h1234);
        check("rdb_hold_valid", bus.rd_b_valid, 1'b0);

        // Same-edge write and read
        wr(2, 16'h0F0F); rda(2); tick();
        check("byp_data",  bus.rd_a_data,  BYP ? 16'h0F0F : 16'h0000);
        check("byp_valid", bus.rd_a_valid, 1'b1);
        rda(2); tick();
        check("after_wr2_data", bus.rd_a_data, 16'h0F0F);

        // Same-edge write + reserve + read on one register
        wr(2, 16'h5555); rsv(2); rda(2); tick();
        check("byp_rsv_data",  bus.rd_a_data,  BYP ? 16'h5555 : 16'h0F0F);
        check("byp_rsv_valid", bus.rd_a_valid, BYP ? 1'b0 : 1'b1);
        check("wr_rsv2_busy",  bus.busy,       6'b000100);
        check("wr_rsv2_err",   bus.rsv_err,    1'b0);
        wr(2, 16'h5555); tick();
        check("wb2_busy", bus.busy, 6'b000000);

        // Register 0 hard-wired zero
        wr(0, 16'hFFFF); rsv(0); tick();
        check("r0_flat", bus.reg_flat[15:0], 16'h0000);
        check("r0_busy", bus.busy, 6'b000000);
        rsv(0); tick();
        check("r0_rsv_err", bus.rsv_err, 1'b0);
        rda(0); tick();
        check("r0_rd_data",  bus.rd_a_data,  16'h0000);
        check("r0_rd_valid", bus.rd_a_valid, 1'b1);

        // Out-of-range selects
        wr(6, 16'hBEEF); rsv(7); rda(3); tick();
        check("oor_flat", bus.reg_flat,
              {16'h1234, 16'h0000, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000});
        check("oor_busy", bus.busy, 6'b000000);
        rsv(7); tick();
        check("oor_rsv_err", bus.rsv_err, 1'b0);
        rda(6); rdb(7); tick();
        check("oor_a_data",  bus.rd_a_data,  16'h0000);
        check("oor_a_valid", bus.rd_a_valid, 1'b0);
        check("oor_b_data",  bus.rd_b_data,  16'h0000);
        check("oor_b_valid", bus.rd_b_valid, 1'b0);

        // Double reserve -> sticky error
        rsv(4); tick();
        check("rsv4_err_first", bus.rsv_err, 1'b0);
        rsv(4); tick();
        check("rsv4_err",  bus.rsv_err, 1'b1);
        check("rsv4_busy", bus.busy,    6'b010000);
        tick(); tick(); tick();
        check("rsv_err_sticky", bus.rsv_err, 1'b1);
        wr(4, 16'h0707); tick();
        check("wb4_busy",      bus.busy,    6'b000000);
        check("wb4_err_stays", bus.rsv_err, 1'b1);

        // Asynchronous reset in the middle of a read
        rda(3);
        @(posedge clk);
        #2;
        idle();
        check("pre_rst_a_valid", bus.rd_a_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("arst_a_valid", bus.rd_a_valid, 1'b0);
        check("arst_a_data",  bus.rd_a_data,  16'h0000);
        check("arst_flat",    bus.reg_flat,   '0);
        check("arst_busy",    bus.busy,       '0);
        check("arst_rsv_err", bus.rsv_err,    1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("post_rst_a_valid", bus.rd_a_valid, 1'b0);

        // Reserve + write on a busy register at one edge is not an error
        rsv(4); tick();
        wr(4, 16'h0BAD); rsv(4); tick();
        check("rsvwr4_err",  bus.rsv_err, 1'b0);
        check("rsvwr4_busy", bus.busy,    6'b010000);
        check("rsvwr4_flat", bus.reg_flat[4*16 +: 16], 16'h0BAD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
